// File: rtl/router_pkg.sv
// ============================================================================
// Module : router_pkg
// Brief  : Shared types, constants and helpers for the 1x3 router write side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [1:0] ADDR_INVALID    = 2'b11;
  localparam int         TIMEOUT_DEFAULT = 30;

  // Port 3 does not exist, so an out-of-range address selects nothing.
  function automatic logic sel_bit(input logic [2:0] v, input logic [1:0] a);
    case (a)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_timeout.sv
// ============================================================================
// Module : router_timeout
// Brief  : Single-port inactivity timer; pulses soft_reset after TIMEOUT
//          consecutive cycles of an unread, non-empty FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic empty,
  input  logic read_enb,
  output logic soft_reset
);

  localparam logic [4:0] c_last = 5'(TIMEOUT - 1);

  logic [4:0] r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count    <= '0;
      soft_reset <= 1'b0;
    end else if (read_enb || empty) begin
      r_count    <= '0;
      soft_reset <= 1'b0;
    end else if (r_count == c_last) begin
      r_count    <= '0;
      soft_reset <= 1'b1;
    end else begin
      r_count    <= r_count + 5'd1;
      soft_reset <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_ctrl.sv
// ============================================================================
// Module : router_ctrl
// Brief  : Write-side controller of the 1x3 router: header decode, packet
//          write sequencing, source throttling and per-port inactivity flush.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module router_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] write_enb,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lp_state,
  output logic       detect_add,
  output logic       busy,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       r_full_on_parity;
  logic       w_sel_full;
  logic       w_abort;
  logic       w_loading;
  logic       w_new_pkt;

  assign vld_out    = ~fifo_empty;
  assign w_sel_full = sel_bit(fifo_full, r_addr);
  assign w_abort    = sel_bit(soft_reset, r_addr) && (r_state != DECODE_ADDRESS);
  assign w_new_pkt  = pkt_valid && (data_in != ADDR_INVALID);

  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_timer
      router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock      (clock),
        .resetn     (resetn),
        .empty      (fifo_empty[i]),
        .read_enb   (read_enb[i]),
        .soft_reset (soft_reset[i])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state          <= DECODE_ADDRESS;
      r_addr           <= '0;
      r_full_on_parity <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE_ADDRESS && w_new_pkt)
        r_addr <= data_in;
      // Remembers whether the stall hit on the parity byte, so the resume
      // knows whether the packet is already complete.
      if (r_state == LOAD_DATA && w_sel_full)
        r_full_on_parity <= 1'b0;
      else if (r_state == LOAD_PARITY && w_sel_full)
        r_full_on_parity <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS:
        if (w_new_pkt)
          w_next = sel_bit(fifo_empty, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:
        if (sel_bit(fifo_empty, r_addr)) w_next = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:
        w_next = LOAD_DATA;
      LOAD_DATA:
        if (w_sel_full)      w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      LOAD_PARITY:
        w_next = w_sel_full ? FIFO_FULL_STATE : CHECK_PARITY_ERROR;
      FIFO_FULL_STATE:
        if (!w_sel_full) w_next = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:
        if (r_full_on_parity) w_next = CHECK_PARITY_ERROR;
        else if (pkt_valid)   w_next = LOAD_DATA;
        else                  w_next = LOAD_PARITY;
      CHECK_PARITY_ERROR:
        w_next = DECODE_ADDRESS;
      default:
        w_next = DECODE_ADDRESS;
    endcase
    if (w_abort) w_next = DECODE_ADDRESS;
  end

  assign detect_add = (r_state == DECODE_ADDRESS);
  assign lfd_state  = (r_state == LOAD_FIRST_DATA);
  assign ld_state   = (r_state == LOAD_DATA);
  assign laf_state  = (r_state == LOAD_AFTER_FULL);
  assign lp_state   = (r_state == LOAD_PARITY);
  assign busy       = !(detect_add || ld_state);
  assign w_loading  = lfd_state || ld_state || lp_state || laf_state;

  always_comb begin
    write_enb = 3'b000;
    if (w_loading && !w_sel_full && !w_abort)
      write_enb = onehot(r_addr);
  end

endmodule

`default_nettype wire

// File: tb/tb_router_ctrl.sv
// ============================================================================
// Module : tb_router_ctrl
// Brief  : Self-checking bench for router_ctrl against a packet-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_router_ctrl;

  localparam int TIMEOUT = 30;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic       lfd_state, ld_state, laf_state, lp_state, detect_add, busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int tests_run    = 0;
  int tests_failed = 0;

  router_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .ld_state   (ld_state),
    .laf_state  (laf_state),
    .lp_state   (lp_state),
    .detect_add (detect_add),
    .busy       (busy),
    .vld_out    (vld_out),
    .soft_reset (soft_reset)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Packet-level view of the controller: what part of a packet is in flight.
  typedef enum {P_IDLE, P_WAIT, P_HEAD, P_BODY, P_PAR, P_STALL, P_RESUME, P_CHECK} phase_t;
  phase_t     ph;
  int         maddr;
  bit         stalled_on_parity;
  int         unread [3];
  logic [2:0] pulse;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE;
    maddr = 0;
    stalled_on_parity = 0;
    pulse = 3'b000;
    for (int i = 0; i < 3; i++) unread[i] = 0;
  endtask

  function automatic bit aborting();
    return pulse[maddr] && ph != P_IDLE;
  endfunction

  task automatic check_outputs();
    logic [2:0] we_exp;
    bit writing;
    writing = (ph == P_HEAD || ph == P_BODY || ph == P_PAR || ph == P_RESUME);
    we_exp = (writing && !fifo_full[maddr] && !aborting()) ? (3'b001 << maddr) : 3'b000;
    check("write_enb",  write_enb, we_exp);
    check("busy",       {2'b00, busy},       {2'b00, !(ph == P_IDLE || ph == P_BODY)});
    check("detect_add", {2'b00, detect_add}, {2'b00, ph == P_IDLE});
    check("lfd_state",  {2'b00, lfd_state},  {2'b00, ph == P_HEAD});
    check("ld_state",   {2'b00, ld_state},   {2'b00, ph == P_BODY});
    check("lp_state",   {2'b00, lp_state},   {2'b00, ph == P_PAR});
    check("laf_state",  {2'b00, laf_state},  {2'b00, ph == P_RESUME});
    check("soft_reset", soft_reset, pulse);
    check("vld_out",    vld_out, ~fifo_empty);
  endtask

  task automatic model_advance();
    bit full;
    full = fifo_full[maddr];
    if (aborting()) ph = P_IDLE;
    else case (ph)
      P_IDLE:
        if (pkt_valid && data_in != 2'b11) begin
          maddr = int'(data_in);
          ph = fifo_empty[maddr] ? P_HEAD : P_WAIT;
        end
      P_WAIT:   if (fifo_empty[maddr]) ph = P_HEAD;
      P_HEAD:   ph = P_BODY;
      P_BODY:
        if (full) begin ph = P_STALL; stalled_on_parity = 0; end
        else if (!pkt_valid) ph = P_PAR;
      P_PAR:
        if (full) begin ph = P_STALL; stalled_on_parity = 1; end
        else ph = P_CHECK;
      P_STALL:  if (!full) ph = P_RESUME;
      P_RESUME: ph = stalled_on_parity ? P_CHECK : (pkt_valid ? P_BODY : P_PAR);
      default:  ph = P_IDLE;
    endcase
    // A port flushes after TIMEOUT consecutive cycles of data nobody reads.
    for (int i = 0; i < 3; i++) begin
      pulse[i] = 1'b0;
      if (read_enb[i] || fifo_empty[i]) unread[i] = 0;
      else begin
        unread[i]++;
        if (unread[i] == TIMEOUT) begin
          pulse[i] = 1'b1;
          unread[i] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    #4;
    check_outputs();
    model_advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 3'b000;
    fifo_empty = 3'b111; read_enb = 3'b000;
  endtask

  int pulses;

  initial begin
    idle_inputs();
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Asynchronous reset in the middle of a packet.
    pkt_valid = 1'b1; data_in = 2'b00;
    repeat (3) cycle();
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check("rst_detect_add", {2'b00, detect_add}, 3'b001);
    check("rst_busy",       {2'b00, busy},       3'b000);
    check("rst_write_enb",  write_enb,           3'b000);
    check("rst_soft_reset", soft_reset,          3'b000);
    @(posedge clock);
    #1 resetn = 1'b1;
    idle_inputs();
    cycle();

    // Port 1 packet: valid for five cycles, then the parity byte.
    pkt_valid = 1'b1; data_in = 2'b01;
    repeat (5) cycle();
    pkt_valid = 1'b0;
    repeat (3) cycle();

    // Port 2 busy: wait until its FIFO drains.
    fifo_empty = 3'b011; read_enb = 3'b100; pkt_valid = 1'b1; data_in = 2'b10;
    repeat (4) cycle();
    fifo_empty = 3'b111;
    repeat (4) cycle();
    pkt_valid = 1'b0;
    repeat (3) cycle();

    // Port 0 fills up mid-payload, then resumes.
    idle_inputs(); pkt_valid = 1'b1; data_in = 2'b00;
    repeat (3) cycle();
    fifo_full = 3'b001;
    repeat (3) cycle();
    fifo_full = 3'b000;
    repeat (3) cycle();
    pkt_valid = 1'b0;
    repeat (3) cycle();

    // Invalid address is dropped.
    pkt_valid = 1'b1; data_in = 2'b11;
    repeat (4) cycle();
    idle_inputs();
    cycle();

    // Timer: 30 unread cycles produce exactly one flush pulse.
    fifo_empty = 3'b101;
    pulses = 0;
    repeat (32) begin
      cycle();
      if (soft_reset[1]) pulses++;
    end
    check("timeout_pulse_count", 3'(pulses), 3'd1);

    // Timer: a read on the 29th cycle prevents the flush.
    read_enb = 3'b010; cycle(); read_enb = 3'b000;
    pulses = 0;
    repeat (28) begin
      cycle();
      if (soft_reset[1]) pulses++;
    end
    read_enb = 3'b010; cycle(); read_enb = 3'b000;
    repeat (3) begin
      cycle();
      if (soft_reset[1]) pulses++;
    end
    check("timeout_read_pulse_count", 3'(pulses), 3'd0);

    // Timer: flushing the selected port aborts the waiting packet.
    read_enb = 3'b010; cycle(); read_enb = 3'b000;
    pkt_valid = 1'b1; data_in = 2'b01;
    cycle();
    pkt_valid = 1'b0;
    repeat (31) cycle();
    check("abort_to_decode", {2'b00, detect_add}, 3'b001);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      pkt_valid  = ($urandom_range(0, 3) != 0);
      data_in    = 2'($urandom_range(0, 3));
      for (int b = 0; b < 3; b++) begin
        fifo_full[b]  = ($urandom_range(0, 7) == 0);
        fifo_empty[b] = ($urandom_range(0, 3) != 0);
        read_enb[b]   = ($urandom_range(0, 1) == 1);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
